spi_sram_responder: RTL and testbench

SPI mode-0 target that emulates a small serial SRAM. It decodes READ (0x03) and WRITE (0x02) commands, each followed by a 16-bit address, and serves or stores bytes from an internal register-file memory. It is the far end of the chip's byte-read SPI master and backs that master in loopback and bring-up benches. It also gives the CPU-side logic a write-notification port and a preload port.

---
 rtl/spi_sram_responder_if.sv | 25 ++
 rtl/spi_sram_responder.sv | 158 +++++++++++++++
 tb/tb_spi_sram_responder.sv | 345 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/spi_sram_responder_if.sv
// SPI pad bundle between a mode-0 master and the SRAM responder.
// The target drives miso/miso_oe; the master drives the rest.
interface spi_sram_responder_if;
  logic cs_n;
  logic sck;
  logic mosi;
  logic miso;
  logic miso_oe;

  modport slave (
    input  cs_n,
    input  sck,
    input  mosi,
    output miso,
    output miso_oe
  );

  modport master (
    output cs_n,
    output sck,
    output mosi,
    input  miso,
    input  miso_oe
  );
endinterface

// File: rtl/spi_sram_responder.sv
// SPI mode-0 serial SRAM target: READ 0x03 / WRITE 0x02 with 16-bit address,
// register-file memory, write notification and local preload port.
module spi_sram_responder #(
  parameter int ADDR_BITS = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  spi_sram_responder_if.slave  spi,
  output logic                 busy,
  output logic                 wr_valid,
  output logic [ADDR_BITS-1:0] wr_addr,
  output logic [7:0]           wr_data,
  input  logic                 init_we,
  input  logic [ADDR_BITS-1:0] init_addr,
  input  logic [7:0]           init_data
);

  localparam int DEPTH = 2 ** ADDR_BITS;

  typedef enum logic [2:0] {
    IDLE, CMD, ADDR, READ, WRITE, IGNORE
  } state_t;

  state_t state, state_n;

  logic [1:0] cs_q, sck_q, mosi_q, ok_q;
  logic       cs_d, sck_d;
  logic       cs_s, sck_s, mosi_s;
  logic       rise, fall, cs_fall;

  logic [7:0]           sh;
  logic [7:0]           sh_in;
  logic [3:0]           cnt;
  logic                 is_rd;
  logic                 miso_r;
  logic [ADDR_BITS-1:0] ptr;
  logic [ADDR_BITS-1:0] ptr_in;
  logic [ADDR_BITS-1:0] ptr_inc;
  logic [7:0]           mem [DEPTH];

  assign cs_s   = cs_q[1];
  assign sck_s  = sck_q[1];
  assign mosi_s = mosi_q[1];

  assign rise    = sck_s & ~sck_d & ~cs_s;
  assign fall    = ~sck_s & sck_d & ~cs_s;
  // cs_d is held low until the synchroniser carries real pad samples,
  // so a reset taken mid-transaction does not fake a select edge.
  assign cs_fall = cs_d & ~cs_s;

  assign sh_in   = {sh[6:0], mosi_s};
  assign ptr_in  = {ptr[ADDR_BITS-2:0], mosi_s};
  assign ptr_inc = ptr + 1'b1;

  assign busy        = ~cs_s;
  assign spi.miso_oe = (state == READ);
  assign spi.miso    = miso_r & (state == READ);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n = state;
    if (cs_s) begin
      state_n = IDLE;
    end else begin
      unique case (state)
        IDLE:
          if (cs_fall) state_n = CMD;
        CMD:
          if (rise && cnt == 4'd7)
            state_n = (sh_in == 8'h03 || sh_in == 8'h02) ? ADDR : IGNORE;
        ADDR:
          if (rise && cnt == 4'd15)
            state_n = is_rd ? READ : WRITE;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cs_q     <= 2'b11;
      sck_q    <= 2'b00;
      mosi_q   <= 2'b00;
      ok_q     <= 2'b00;
      cs_d     <= 1'b0;
      sck_d    <= 1'b0;
      sh       <= '0;
      cnt      <= '0;
      is_rd    <= 1'b0;
      miso_r   <= 1'b0;
      ptr      <= '0;
      wr_valid <= 1'b0;
      wr_addr  <= '0;
      wr_data  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= 8'h00;
    end else begin
      cs_q     <= {cs_q[0], spi.cs_n};
      sck_q    <= {sck_q[0], spi.sck};
      mosi_q   <= {mosi_q[0], spi.mosi};
      ok_q     <= {ok_q[0], 1'b1};
      cs_d     <= ok_q[1] ? cs_s : 1'b0;
      sck_d    <= sck_s;
      wr_valid <= 1'b0;
      if (init_we && !busy) mem[init_addr] <= init_data;
      unique case (state)
        IDLE: cnt <= '0;
        CMD:
          if (rise) begin
            sh  <= sh_in;
            cnt <= cnt + 1'b1;
            if (cnt == 4'd7) begin
              cnt   <= '0;
              is_rd <= (sh_in == 8'h03);
            end
          end
        ADDR:
          if (rise) begin
            ptr <= ptr_in;
            cnt <= cnt + 1'b1;
            if (cnt == 4'd15) begin
              cnt    <= '0;
              sh     <= mem[ptr_in];
              miso_r <= 1'b0;
            end
          end
        READ:
          if (fall && cnt != 4'd8) begin
            miso_r <= sh[7];
            sh     <= {sh[6:0], 1'b0};
            cnt    <= cnt + 1'b1;
          end else if (rise && cnt == 4'd8) begin
            ptr <= ptr_inc;
            sh  <= mem[ptr_inc];
            cnt <= '0;
          end
        WRITE:
          if (rise) begin
            sh  <= sh_in;
            cnt <= cnt + 1'b1;
            if (cnt == 4'd7) begin
              cnt      <= '0;
              mem[ptr] <= sh_in;
              wr_valid <= 1'b1;
              wr_addr  <= ptr;
              wr_data  <= sh_in;
              ptr      <= ptr_inc;
            end
          end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_sram_responder.sv
// Directed bench for spi_sram_responder: drives a mode-0 SPI master
// and checks reads, writes, wrap, unknown commands and aborts.
module tb_spi_sram_responder;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       busy, wr_valid;
  logic [3:0] wr_addr;
  logic [7:0] wr_data;
  logic       init_we = 1'b0;
  logic [3:0] init_addr = '0;
  logic [7:0] init_data = '0;

  int checks = 0;
  int errors = 0;

  logic       oe_seen = 1'b0;
  logic       miso_bad = 1'b0;
  logic [3:0] wa_q[$];
  logic [7:0] wd_q[$];

  spi_sram_responder_if spi();

  spi_sram_responder #(.ADDR_BITS(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .spi       (spi.slave),
    .busy      (busy),
    .wr_valid  (wr_valid),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .init_we   (init_we),
    .init_addr (init_addr),
    .init_data (init_data)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (wr_valid) begin
      wa_q.push_back(wr_addr);
      wd_q.push_back(wr_data);
    end
    if (spi.miso_oe) oe_seen <= 1'b1;
    if (!spi.miso_oe && spi.miso) miso_bad <= 1'b1;
  end

  task automatic spi_bit(input logic b, output logic r);
    spi.mosi = b;
    repeat (5) @(negedge clk);
    r = spi.miso;
    spi.sck = 1'b1;
    repeat (5) @(negedge clk);
    spi.sck = 1'b0;
  endtask

  task automatic spi_byte(input logic [7:0] tx, output logic [7:0] rx);
    logic r;
    for (int i = 7; i >= 0; i--) begin
      spi_bit(tx[i], r);
      rx[i] = r;
    end
  endtask

  task automatic cs_begin();
    @(negedge clk);
    spi.cs_n = 1'b0;
    repeat (5) @(negedge clk);
  endtask

  task automatic cs_end();
    repeat (5) @(negedge clk);
    spi.cs_n = 1'b1;
    spi.mosi = 1'b0;
    repeat (6) @(negedge clk);
  endtask

  task automatic preload(input logic [3:0] a, input logic [7:0] d);
    @(negedge clk);
    init_we   = 1'b1;
    init_addr = a;
    init_data = d;
    @(negedge clk);
    init_we = 1'b0;
  endtask

  task automatic read2(input logic [15:0] a,
                       output logic [7:0] b0, output logic [7:0] b1);
    logic [7:0] rx;
    cs_begin();
    spi_byte(8'h03, rx);
    spi_byte(a[15:8], rx);
    spi_byte(a[7:0], rx);
    spi_byte(8'h00, b0);
    spi_byte(8'h00, b1);
    cs_end();
  endtask

  task automatic test_reset();
    logic [7:0] b0, b1;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({spi.miso, spi.miso_oe, busy, wr_valid} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_bits got %b want 0000",
               {spi.miso, spi.miso_oe, busy, wr_valid});
    end
    checks++;
    if ({wr_addr, wr_data} !== 12'h000) begin
      errors++;
      $display("FAIL reset_wr got %h want 000", {wr_addr, wr_data});
    end
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_busy got %b want 0", busy);
    end
    read2(16'h0007, b0, b1);
    checks++;
    if (b0 !== 8'h00) begin
      errors++;
      $display("FAIL reset_read7 got %h want 00", b0);
    end
  endtask

  task automatic test_preload_read();
    logic [7:0] rx;
    preload(4'd5, 8'hA5);
    wa_q.delete();
    wd_q.delete();
    cs_begin();
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL busy_sel got %b want 1", busy);
    end
    oe_seen = 1'b0;
    spi_byte(8'h03, rx);
    spi_byte(8'h00, rx);
    checks++;
    if (oe_seen !== 1'b0) begin
      errors++;
      $display("FAIL oe_early got %b want 0", oe_seen);
    end
    spi_byte(8'h05, rx);
    checks++;
    if (spi.miso_oe !== 1'b1) begin
      errors++;
      $display("FAIL oe_read got %b want 1", spi.miso_oe);
    end
    spi_byte(8'h00, rx);
    cs_end();
    checks++;
    if (rx !== 8'hA5) begin
      errors++;
      $display("FAIL preload_read got %h want a5", rx);
    end
    checks++;
    if (wa_q.size() !== 0) begin
      errors++;
      $display("FAIL preload_wr got %0d pulses want 0", wa_q.size());
    end
    checks++;
    if (spi.miso_oe !== 1'b0) begin
      errors++;
      $display("FAIL oe_after_cs got %b want 0", spi.miso_oe);
    end
  endtask

  task automatic test_write_readback();
    logic [7:0] rx, b0, b1;
    wa_q.delete();
    wd_q.delete();
    cs_begin();
    spi_byte(8'h02, rx);
    spi_byte(8'h00, rx);
    spi_byte(8'h03, rx);
    spi_byte(8'h3C, rx);
    spi_byte(8'h7E, rx);
    cs_end();
    checks++;
    if (wa_q.size() !== 2) begin
      errors++;
      $display("FAIL wr_count got %0d want 2", wa_q.size());
    end else begin
      checks++;
      if ({wa_q[0], wd_q[0]} !== 12'h33C) begin
        errors++;
        $display("FAIL wr_first got %h want 33c", {wa_q[0], wd_q[0]});
      end
      checks++;
      if ({wa_q[1], wd_q[1]} !== 12'h47E) begin
        errors++;
        $display("FAIL wr_second got %h want 47e", {wa_q[1], wd_q[1]});
      end
    end
    read2(16'h0003, b0, b1);
    checks++;
    if ({b0, b1} !== 16'h3C7E) begin
      errors++;
      $display("FAIL readback got %h want 3c7e", {b0, b1});
    end
  endtask

  task automatic test_wrap();
    logic [7:0] b0, b1;
    preload(4'd15, 8'h11);
    preload(4'd0, 8'h22);
    read2(16'hAB0F, b0, b1);
    checks++;
    if ({b0, b1} !== 16'h1122) begin
      errors++;
      $display("FAIL wrap_mask got %h want 1122", {b0, b1});
    end
  endtask

  task automatic test_unknown();
    logic [7:0] rx, b0, b1;
    logic [23:0] acc;
    wa_q.delete();
    wd_q.delete();
    oe_seen  = 1'b0;
    miso_bad = 1'b0;
    cs_begin();
    spi_byte(8'h9F, rx);
    spi_byte(8'hFF, acc[23:16]);
    spi_byte(8'hFF, acc[15:8]);
    spi_byte(8'hFF, acc[7:0]);
    cs_end();
    checks++;
    if ({oe_seen, miso_bad, acc} !== 26'h0) begin
      errors++;
      $display("FAIL unk_miso got oe=%b bad=%b data=%h want 0",
               oe_seen, miso_bad, acc);
    end
    checks++;
    if (wa_q.size() !== 0) begin
      errors++;
      $display("FAIL unk_wr got %0d pulses want 0", wa_q.size());
    end
    read2(16'h0004, b0, b1);
    checks++;
    if ({b0, b1} !== 16'h7EA5) begin
      errors++;
      $display("FAIL unk_after got %h want 7ea5", {b0, b1});
    end
  endtask

  task automatic test_abort_write();
    logic [7:0] rx, b0, b1;
    logic r;
    wa_q.delete();
    wd_q.delete();
    cs_begin();
    spi_byte(8'h02, rx);
    spi_byte(8'h00, rx);
    spi_byte(8'h02, rx);
    for (int i = 0; i < 5; i++) spi_bit(1'b1, r);
    cs_end();
    checks++;
    if (wa_q.size() !== 0) begin
      errors++;
      $display("FAIL abort_wr got %0d pulses want 0", wa_q.size());
    end
    read2(16'h0002, b0, b1);
    checks++;
    if ({b0, b1} !== 16'h003C) begin
      errors++;
      $display("FAIL abort_mem got %h want 003c", {b0, b1});
    end
  endtask

  task automatic test_init_busy();
    logic [7:0] b0, b1;
    cs_begin();
    preload(4'd6, 8'hFF);
    cs_end();
    read2(16'h0006, b0, b1);
    checks++;
    if (b0 !== 8'h00) begin
      errors++;
      $display("FAIL init_busy got %h want 00", b0);
    end
  endtask

  task automatic test_rst_mid_read();
    logic [7:0] rx, b0, b1;
    logic r;
    preload(4'd9, 8'h5A);
    cs_begin();
    spi_byte(8'h03, rx);
    spi_byte(8'h00, rx);
    spi_byte(8'h09, rx);
    for (int i = 0; i < 3; i++) spi_bit(1'b0, r);
    checks++;
    if (spi.miso_oe !== 1'b1) begin
      errors++;
      $display("FAIL rst_pre_oe got %b want 1", spi.miso_oe);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({spi.miso_oe, spi.miso} !== 2'b00) begin
      errors++;
      $display("FAIL rst_oe got %b want 00", {spi.miso_oe, spi.miso});
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    oe_seen = 1'b0;
    for (int i = 0; i < 32; i++) spi_bit(1'b1, r);
    checks++;
    if (oe_seen !== 1'b0) begin
      errors++;
      $display("FAIL rst_idle got oe=%b want 0", oe_seen);
    end
    cs_end();
    read2(16'h0009, b0, b1);
    checks++;
    if (b0 !== 8'h00) begin
      errors++;
      $display("FAIL rst_mem got %h want 00", b0);
    end
  endtask

  initial begin
    spi.cs_n = 1'b1;
    spi.sck  = 1'b0;
    spi.mosi = 1'b0;
    test_reset();
    test_preload_read();
    test_write_readback();
    test_wrap();
    test_unknown();
    test_abort_write();
    test_init_busy();
    test_rst_mid_read();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
